// File: rtl/pixel_stream_pkg.sv
// Shared pixel-stream types and column bit positions used by the line buffer
// and the downstream 3x3 convolution stage.
package pixel_stream_pkg;

    typedef logic [10:0] hcount_t;
    typedef logic [9:0]  vcount_t;
    typedef logic [2:0]  column_t;

    localparam int unsigned COL_BELOW  = 0;
    localparam int unsigned COL_CENTER = 1;
    localparam int unsigned COL_ABOVE  = 2;

    // Row above the newest one, wrapping row 0 back to the previous frame's last row.
    function automatic vcount_t center_row(input vcount_t y, input vcount_t rows);
        vcount_t r;
        if (y == '0) begin
            r = rows - vcount_t'(1);
        end else begin
            r = y - vcount_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/binary_line_buffer_if.sv
// Pixel-in / column-out bundle of the binary line buffer.
// master drives pixels and observes columns; slave is the buffer itself.
interface binary_line_buffer_if;
    import pixel_stream_pkg::*;

    logic    data_in;
    hcount_t hcount_in;
    vcount_t vcount_in;
    logic    data_valid_in;

    logic    data_valid_out;
    hcount_t hcount_out;
    vcount_t vcount_out;
    column_t data_out;

    modport master (
        output data_in,
        output hcount_in,
        output vcount_in,
        output data_valid_in,
        input  data_valid_out,
        input  hcount_out,
        input  vcount_out,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  hcount_in,
        input  vcount_in,
        input  data_valid_in,
        output data_valid_out,
        output hcount_out,
        output vcount_out,
        output data_out
    );

endinterface

// File: rtl/line_ram_1b.sv
// Single-port 1-bit x DEPTH memory, synchronous read-first (read returns old data).
module line_ram_1b #(
    parameter int DEPTH = 320,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_in,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic          wdata_i,
    output logic          rdata_o
);

    logic mem_q [DEPTH];
    logic rdata_q;

    always_ff @(posedge clk_in) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/binary_line_buffer.sv
// Three-row line buffer for 1-bit pixels, emitting {y-2, y-1, y} columns.
// LINE_BUFFER_EDGE_ZERO_EN: zero out-of-frame bits instead of replicating centre.
module binary_line_buffer
    import pixel_stream_pkg::*;
#(
    parameter int H_PIXELS = 320,
    parameter int V_PIXELS = 180
) (
    input logic                 clk_in,
    input logic                 rst_in,
    binary_line_buffer_if.slave bus
);

    localparam int      AW    = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam hcount_t H_MAX = hcount_t'(H_PIXELS);
    localparam vcount_t V_MAX = vcount_t'(V_PIXELS);

    logic          accept;
    logic [AW-1:0] addr;
    logic          rd0;
    logic          rd1;

    logic    vld1_q, vld1_d;
    logic    d1_q;
    logic    sel1_q;
    hcount_t h1_q;
    vcount_t v1_q;

    logic    vld2_q;
    hcount_t h2_q;
    vcount_t v2_q;
    column_t col2_q;

    logic    above;
    logic    center;
    column_t col_d;
    vcount_t vout_d;

    // Pixels seen while in reset never reach the memories or the valid pipe.
    assign accept = bus.data_valid_in && !rst_in
                    && (bus.hcount_in < H_MAX)
                    && (bus.vcount_in < V_MAX);
    assign addr   = bus.hcount_in[AW-1:0];
    assign vld1_d = accept;

    line_ram_1b #(.DEPTH(H_PIXELS)) u_ram0 (
        .clk_in  (clk_in),
        .en_i    (accept),
        .we_i    (accept && !bus.vcount_in[0]),
        .addr_i  (addr),
        .wdata_i (bus.data_in),
        .rdata_o (rd0)
    );

    line_ram_1b #(.DEPTH(H_PIXELS)) u_ram1 (
        .clk_in  (clk_in),
        .en_i    (accept),
        .we_i    (accept && bus.vcount_in[0]),
        .addr_i  (addr),
        .wdata_i (bus.data_in),
        .rdata_o (rd1)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld1_q <= 1'b0;
            d1_q   <= 1'b0;
            sel1_q <= 1'b0;
            h1_q   <= '0;
            v1_q   <= '0;
        end else begin
            vld1_q <= vld1_d;
            if (accept) begin
                d1_q   <= bus.data_in;
                sel1_q <= bus.vcount_in[0];
                h1_q   <= bus.hcount_in;
                v1_q   <= bus.vcount_in;
            end
        end
    end

    // mem[y[0]] held row y-2 before this write; mem[~y[0]] holds row y-1.
    always_comb begin
        above  = sel1_q ? rd1 : rd0;
        center = sel1_q ? rd0 : rd1;
        col_d  = '0;
        col_d[COL_BELOW]  = d1_q;
        col_d[COL_CENTER] = center;
        col_d[COL_ABOVE]  = above;
`ifdef LINE_BUFFER_EDGE_ZERO_EN
        if (v1_q == vcount_t'(0)) begin
            col_d[COL_BELOW] = 1'b0;
        end
        if (v1_q == vcount_t'(1)) begin
            col_d[COL_ABOVE] = 1'b0;
        end
`else
        if (v1_q == vcount_t'(0)) begin
            col_d[COL_BELOW] = center;
        end
        if (v1_q == vcount_t'(1)) begin
            col_d[COL_ABOVE] = center;
        end
`endif
        vout_d = center_row(v1_q, V_MAX);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld2_q <= 1'b0;
            h2_q   <= '0;
            v2_q   <= '0;
            col2_q <= '0;
        end else begin
            vld2_q <= vld1_q;
            if (vld1_q) begin
                h2_q   <= h1_q;
                v2_q   <= vout_d;
                col2_q <= col_d;
            end
        end
    end

    assign bus.data_valid_out = vld2_q;
    assign bus.hcount_out     = h2_q;
    assign bus.vcount_out     = v2_q;
    assign bus.data_out       = col2_q;

endmodule

// File: tb/tb_binary_line_buffer.sv
// Scoreboard bench for binary_line_buffer (H_PIXELS=8, V_PIXELS=4).
module tb_binary_line_buffer;
    import pixel_stream_pkg::*;

    localparam int H = 8;
    localparam int V = 4;
`ifdef LINE_BUFFER_EDGE_ZERO_EN
    localparam bit EZ = 1'b1;
`else
    localparam bit EZ = 1'b0;
`endif

    typedef struct {
        int      due;
        hcount_t h;
        vcount_t v;
        column_t d;
        column_t m;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    binary_line_buffer_if bus ();

    binary_line_buffer #(.H_PIXELS(H), .V_PIXELS(V)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic raw(input logic vld, input logic d, input int h, input int v);
        @(posedge clk);
        #1;
        bus.data_valid_in = vld;
        bus.data_in       = d;
        bus.hcount_in     = hcount_t'(h);
        bus.vcount_in     = vcount_t'(v);
    endtask

    task automatic px(input logic d, input int h, input int v,
                      input int ev, input column_t ed, input column_t em);
        exp_t e;
        raw(1'b1, d, h, v);
        e.due = cyc + 2;
        e.h   = hcount_t'(h);
        e.v   = vcount_t'(ev);
        e.d   = ed;
        e.m   = em;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.data_valid_in = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.data_valid_out) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid h=%0d v=%0d d=%b",
                         bus.hcount_out, bus.vcount_out, bus.data_out);
            end else begin
                e = sb.pop_front();
                chk("latency", cyc, e.due);
                chk("hcount", 32'(bus.hcount_out), 32'(e.h));
                chk("vcount", 32'(bus.vcount_out), 32'(e.v));
                if (e.m != '0) begin
                    chk("column", 32'(bus.data_out & e.m), 32'(e.d & e.m));
                end
            end
        end
    end

    initial begin
        logic [7:0] p;
        logic [7:0] q;
        int         n;
        p = 8'b0110_1001;
        q = 8'b1100_0011;
        bus.data_valid_in = 1'b0;
        bus.data_in       = 1'b0;
        bus.hcount_in     = '0;
        bus.vcount_in     = '0;

        // reset with live traffic: outputs stay zero, traffic discarded
        for (int i = 0; i < 4; i++) begin
            raw(1'b1, 1'b1, i, 0);
            @(negedge clk);
            chk("reset_outputs",
                {7'd0, bus.data_valid_out, bus.hcount_out, bus.vcount_out, bus.data_out},
                32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.data_valid_in = 1'b0;
        @(negedge clk);
        chk("post_reset_valid0", 32'(bus.data_valid_out), 32'd0);
        @(negedge clk);
        chk("post_reset_valid1", 32'(bus.data_valid_out), 32'd0);

        // frame A: row0 ones (history unknown), row1 zeros, row2 ones, row3 p
        for (int x = 0; x < H; x++)
            px(1'b1, x, 0, 3, 3'b000, EZ ? 3'b001 : 3'b000);
        for (int x = 0; x < H; x++)
            px(1'b0, x, 1, 0, EZ ? 3'b010 : 3'b110, 3'b111);
        for (int x = 0; x < H; x++)
            px(1'b1, x, 2, 1, 3'b101, 3'b111);
        for (int x = 0; x < H; x++)
            px(p[x], x, 3, 2, {1'b0, 1'b1, p[x]}, 3'b111);

        // frame B row0 with gaps between pixels
        for (int x = 0; x < H; x++) begin
            px(q[x], x, 0, 3, {1'b1, p[x], EZ ? 1'b0 : p[x]}, 3'b111);
            idle();
        end
        for (int x = 0; x < H; x++)
            px(1'b0, x, 1, 0, {EZ ? 1'b0 : q[x], q[x], 1'b0}, 3'b111);

        // out-of-range pixels that would corrupt row0 if written
        raw(1'b1, 1'b0, 8, 2);
        raw(1'b1, 1'b1, 3, 4);
        raw(1'b1, 1'b1, 11, 0);
        idle();
        idle();

        for (int x = 0; x < H; x++)
            px(1'b0, x, 2, 1, {q[x], 1'b0, 1'b0}, 3'b111);
        for (int x = 0; x < H; x++)
            px(1'b1, x, 3, 2, 3'b001, 3'b111);

        idle();
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
